mem_port_arbiter: RTL and testbench

//  Shares one single-ported, variable-latency memory between the pipeline's fetch port
//  (I-side) and its memory-stage load/store port (D-side). Grants one requester at a time

---
 rtl/mips_pkg.sv | 12 +
 rtl/mem_arb_watchdog.sv | 31 +++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the memory port arbiter
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - busy-cycle watchdog for the memory port arbiter
module mem_arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic busy,
    input  logic ack,
    output logic expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Counter restarts on every grant and advances for each busy cycle that sees no ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (busy && !ack && !expire) begin
            count <= count + 1'b1;
        end
    end

    assign expire = busy && !ack && (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - I/D arbiter onto one variable-latency memory port (optional watchdog: MEM_ARB_TIMEOUT_EN)
import mips_pkg::*;

module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          arb_err
);

    arb_state_t state;
    logic       lastD;
    logic       iCand;
    logic       dCand;
    logic       grantD;
    logic       grantI;
    logic       expire;

    // A side whose ready pulse is out this cycle still shows its old req; mask it
    // so the same request is not serviced twice.
    assign iCand  = i_req && !i_ready;
    assign dCand  = d_req && !d_ready;
    assign grantD = (state == IDLE) && dCand && (!iCand || !lastD);
    assign grantI = (state == IDLE) && iCand && !grantD;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .start  (grantD || grantI),
        .busy   (state != IDLE),
        .ack    (mem_ack),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // Grant FSM with registered memory-port and completion outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lastD     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            arb_err   <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grantD) begin
                        state     <= BUSY_D;
                        lastD     <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end else if (grantI) begin
                        state     <= BUSY_I;
                        lastD     <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        i_rdata <= mem_rdata;
                        i_ready <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= IDLE;
                    end else if (expire) begin
                        i_rdata <= DW'(ARB_TIMEOUT_DATA);
                        i_ready <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        arb_err <= 1'b1;
                        state   <= IDLE;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        // Stores leave the last load data in place.
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                        d_ready <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= IDLE;
                    end else if (expire) begin
                        d_rdata <= DW'(ARB_TIMEOUT_DATA);
                        d_ready <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        arb_err <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        arb_err;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .arb_err   (arb_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        checks++;
        if ({mem_req, mem_we, i_ready, d_ready, arb_err} !== 5'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: req=%b we=%b ir=%b dr=%b err=%b addr=%h wd=%h ird=%h drd=%h required all 0",
                     mem_req, mem_we, i_ready, d_ready, arb_err, mem_addr, mem_wdata, i_rdata, d_rdata);
        end
        rst = 0;
    endtask

    task automatic test_load();
        d_req = 1; d_we = 0; d_addr = 32'h40;
        step();
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40 || d_ready !== 1'b0) begin
                failures++;
                $display("FAIL load_access c%0d: req=%b we=%b addr=%h dr=%b required 1 0 00000040 0",
                         c, mem_req, mem_we, mem_addr, d_ready);
            end
            if (c == 2) begin
                mem_ack = 1; mem_rdata = 32'h1234;
            end
            step();
        end
        checks++;
        if (d_ready !== 1'b1 || d_rdata !== 32'h1234 || i_ready !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL load_done: dr=%b drd=%h ir=%b req=%b required 1 00001234 0 0",
                     d_ready, d_rdata, i_ready, mem_req);
        end
        d_req = 0; mem_ack = 0;
        step();
        checks++;
        if (d_ready !== 1'b0 || d_rdata !== 32'h1234) begin
            failures++;
            $display("FAIL load_pulse_width: dr=%b drd=%h required 0 00001234", d_ready, d_rdata);
        end
    endtask

    task automatic test_store();
        d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'hCAFE;
        step();
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 32'hCAFE) begin
                failures++;
                $display("FAIL store_access c%0d: req=%b we=%b addr=%h wd=%h required 1 1 00000080 0000cafe",
                         c, mem_req, mem_we, mem_addr, mem_wdata);
            end
            if (c == 2) begin
                mem_ack = 1; mem_rdata = 32'hFFFF_0000;
            end
            step();
        end
        checks++;
        if (d_ready !== 1'b1 || d_rdata !== 32'h1234 || mem_we !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL store_done: dr=%b drd=%h we=%b req=%b required 1 00001234 0 0",
                     d_ready, d_rdata, mem_we, mem_req);
        end
        d_req = 0; d_we = 0; mem_ack = 0;
        step();
    endtask

    task automatic test_contention();
        logic expD;
        logic expI;
        logic [31:0] expAddr;
        do_reset();
        i_req = 1; d_req = 1; i_addr = 32'h10; d_addr = 32'hD0; mem_ack = 1; mem_rdata = 32'h100;
        for (int c = 1; c <= 8; c++) begin
            step();
            expD = (c == 2 || c == 6);
            expI = (c == 4 || c == 8);
            checks++;
            if (d_ready !== expD || i_ready !== expI) begin
                failures++;
                $display("FAIL contention_ready c%0d: dr=%b ir=%b required %b %b", c, d_ready, i_ready, expD, expI);
            end
            if (c % 2 == 1) begin
                expAddr = (c == 1 || c == 5) ? 32'hD0 : 32'h10;
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== expAddr) begin
                    failures++;
                    $display("FAIL contention_grant c%0d: req=%b addr=%h required 1 %h", c, mem_req, mem_addr, expAddr);
                end
            end
            if (expD) begin
                checks++;
                if (d_rdata !== 32'h100 + 32'(c - 1)) begin
                    failures++;
                    $display("FAIL contention_ddata c%0d: drd=%h required %h", c, d_rdata, 32'h100 + 32'(c - 1));
                end
            end
            if (expI) begin
                checks++;
                if (i_rdata !== 32'h100 + 32'(c - 1)) begin
                    failures++;
                    $display("FAIL contention_idata c%0d: ird=%h required %h", c, i_rdata, 32'h100 + 32'(c - 1));
                end
            end
            mem_rdata = 32'h100 + 32'(c);
        end
        i_req = 0; d_req = 0;
        step();
        mem_ack = 0;
        checks++;
        if (mem_req !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0) begin
            failures++;
            $display("FAIL contention_drain: req=%b ir=%b dr=%b required 0 0 0", mem_req, i_ready, d_ready);
        end
    endtask

    task automatic test_stall();
        mem_ack = 1; mem_rdata = 32'h5555;
        step();
        step();
        mem_ack = 0;
        checks++;
        if (mem_req !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0 || i_rdata !== 32'h107) begin
            failures++;
            $display("FAIL stray_ack: req=%b ir=%b dr=%b ird=%h required 0 0 0 00000107",
                     mem_req, i_ready, d_ready, i_rdata);
        end
        i_req = 1; i_addr = 32'h200;
        step();
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h200 || mem_wdata !== 32'h0 || i_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold c%0d: req=%b we=%b addr=%h wd=%h ir=%b required 1 0 00000200 0 0",
                         c, mem_req, mem_we, mem_addr, mem_wdata, i_ready);
            end
            if (c == 3) i_req = 0;
            if (c == 10) begin
                mem_ack = 1; mem_rdata = 32'hABCD;
            end
            step();
        end
        checks++;
        if (i_ready !== 1'b1 || i_rdata !== 32'hABCD || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL stall_done: ir=%b ird=%h req=%b required 1 0000abcd 0", i_ready, i_rdata, mem_req);
        end
        mem_ack = 0;
        step();
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'h77;
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
            failures++;
            $display("FAIL midrst_busy: req=%b addr=%h required 1 00000300", mem_req, mem_addr);
        end
        rst = 1;
        #1;
        checks++;
        if ({mem_req, mem_we, i_ready, d_ready, arb_err} !== 5'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL midrst_async: req=%b we=%b ir=%b dr=%b addr=%h wd=%h ird=%h drd=%h required all 0",
                     mem_req, mem_we, i_ready, d_ready, mem_addr, mem_wdata, i_rdata, d_rdata);
        end
        step();
        rst = 0; d_req = 0; d_we = 0;
        step();
        checks++;
        if (d_ready !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL midrst_no_ready: dr=%b req=%b required 0 0", d_ready, mem_req);
        end
        d_req = 1; d_addr = 32'h44;
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h44 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL midrst_next_req: req=%b addr=%h we=%b required 1 00000044 0", mem_req, mem_addr, mem_we);
        end
        mem_ack = 1; mem_rdata = 32'h4444;
        step();
        checks++;
        if (d_ready !== 1'b1 || d_rdata !== 32'h4444) begin
            failures++;
            $display("FAIL midrst_next_done: dr=%b drd=%h required 1 00004444", d_ready, d_rdata);
        end
        d_req = 0; mem_ack = 0;
        step();
    endtask

    task automatic test_timeout();
`ifdef MEM_ARB_TIMEOUT_EN
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h500;
        step();
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (mem_req !== 1'b1 || d_ready !== 1'b0 || arb_err !== 1'b0) begin
                failures++;
                $display("FAIL timeout_wait c%0d: req=%b dr=%b err=%b required 1 0 0", c, mem_req, d_ready, arb_err);
            end
            step();
        end
        checks++;
        if (d_ready !== 1'b1 || d_rdata !== 32'hDEAD_BEEF || arb_err !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL timeout_fire: dr=%b drd=%h err=%b req=%b required 1 deadbeef 1 0",
                     d_ready, d_rdata, arb_err, mem_req);
        end
        d_req = 0;
        step();
        step();
        checks++;
        if (arb_err !== 1'b1 || d_ready !== 1'b0) begin
            failures++;
            $display("FAIL timeout_sticky: err=%b dr=%b required 1 0", arb_err, d_ready);
        end
        do_reset();
        checks++;
        if (arb_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: err=%b required 0", arb_err);
        end
`else
        checks++;
        if (arb_err !== 1'b0) begin
            failures++;
            $display("FAIL err_tied: err=%b required 0", arb_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_contention();
        test_stall();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
